// File: rtl/text_overlay_renderer_pkg.sv
// Shared constants, message table and glyph data for the text overlay renderer.
// Exports: GLYPH_W/GLYPH_H, character codes, msg_t, MSG_TABLE, glyph_bits().
// Character codes are ASCII positions; code 8'h00 is the blank glyph.
package text_pkg;

   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int MSG_CHARS = 16;   // storage width of one table entry
   localparam int MSG_COUNT = 4;    // entries in the default table

   localparam logic [7:0] CH_BLANK = 8'h00;
   localparam logic [7:0] CH_0 = 8'h30, CH_1 = 8'h31, CH_2 = 8'h32, CH_3 = 8'h33, CH_4 = 8'h34;
   localparam logic [7:0] CH_5 = 8'h35, CH_6 = 8'h36, CH_7 = 8'h37, CH_8 = 8'h38, CH_9 = 8'h39;
   localparam logic [7:0] CH_A = 8'h41, CH_B = 8'h42, CH_C = 8'h43, CH_D = 8'h44, CH_E = 8'h45;
   localparam logic [7:0] CH_F = 8'h46, CH_G = 8'h47, CH_H = 8'h48, CH_I = 8'h49, CH_J = 8'h4A;
   localparam logic [7:0] CH_K = 8'h4B, CH_L = 8'h4C, CH_M = 8'h4D, CH_N = 8'h4E, CH_O = 8'h4F;
   localparam logic [7:0] CH_P = 8'h50, CH_Q = 8'h51, CH_R = 8'h52, CH_S = 8'h53, CH_T = 8'h54;
   localparam logic [7:0] CH_U = 8'h55, CH_V = 8'h56, CH_W = 8'h57, CH_X = 8'h58, CH_Y = 8'h59;
   localparam logic [7:0] CH_Z = 8'h5A;

   // Index 0 is the leftmost character.
   typedef logic [MSG_CHARS-1:0][7:0] msg_t;

   // Converts a right-justified string literal of 'len' characters into a
   // left-to-right message; spaces become the blank code, the tail stays blank.
   function automatic msg_t str_to_msg(input logic [8*MSG_CHARS-1:0] s, input int len);
      msg_t       m;
      logic [7:0] c;
      m = '0;
      for (int i = 0; i < MSG_CHARS; i++) begin
         if (i < len) begin
            c    = s[8*(len-1-i) +: 8];
            m[i] = (c == 8'h20) ? CH_BLANK : c;
         end
      end
      return m;
   endfunction

   localparam msg_t MSG_TABLE [MSG_COUNT] = '{
      str_to_msg(128'("PRESS START"), 11),
      str_to_msg(128'("GAME OVER"),    9),
      str_to_msg(128'("SCORE"),        5),
      str_to_msg(128'("HI SCORE"),     8)
   };

   // 8x16 glyphs, row 0 in the top byte, bit 7 = leftmost pixel.
   // Codes without an entry render blank.
   function automatic logic [127:0] glyph_bits(input logic [6:0] code);
      case (code)
         7'h41:   return 128'h00001038_6cc6c6fe_c6c6c6c6_00000000; // A
         7'h43:   return 128'h00003c66_c2c0c0c0_c0c2663c_00000000; // C
         7'h45:   return 128'h0000fe66_62687868_606266fe_00000000; // E
         7'h47:   return 128'h00003c66_c2c0c0de_c6c6663a_00000000; // G
         7'h48:   return 128'h0000c6c6_c6c6fec6_c6c6c6c6_00000000; // H
         7'h49:   return 128'h00003c18_18181818_1818183c_00000000; // I
         7'h4D:   return 128'h0000c6ee_fefed6c6_c6c6c6c6_00000000; // M
         7'h4F:   return 128'h00007cc6_c6c6c6c6_c6c6c67c_00000000; // O
         7'h50:   return 128'h0000fc66_66667c60_606060f0_00000000; // P
         7'h52:   return 128'h0000fc66_66667c6c_666666e6_00000000; // R
         7'h53:   return 128'h00007cc6_c660380c_06c6c67c_00000000; // S
         7'h54:   return 128'h00007e7e_5a181818_1818183c_00000000; // T
         7'h56:   return 128'h0000c6c6_c6c6c6c6_c66c3810_00000000; // V
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/text_overlay_renderer_if.sv
// Pixel-stream interface between the VGA timing side and the text overlay.
// Carries frame pulse, pixel coordinates, per-frame controls and the two overlay outputs.
// master = timing/colour side, slave = renderer.
interface text_overlay_renderer_if #(
   parameter int N_MSGS = 4
);
   localparam int MSW = (N_MSGS > 1) ? $clog2(N_MSGS) : 1;

   logic           frame_start;
   logic [9:0]     DrawX;
   logic [9:0]     DrawY;
   logic [MSW-1:0] msg_sel;
   logic           enable;
   logic           blink_en;
   logic           pixel_on;
   logic           in_box;

   modport master (
      output frame_start, DrawX, DrawY, msg_sel, enable, blink_en,
      input  pixel_on, in_box
   );

   modport slave (
      input  frame_start, DrawX, DrawY, msg_sel, enable, blink_en,
      output pixel_on, in_box
   );
endinterface

// File: rtl/text_overlay_renderer_glyph_font_rom.sv
// Synchronous 2048x8 font ROM: addr = {code[6:0], row[3:0]}, data = glyph row bits.
// Ports: Clk, addr[10:0] in; data[7:0] out, one cycle after addr.
// No reset: contents are constant and consumers qualify data with their own valid.
module glyph_font_rom
   import text_pkg::*;
(
   input  logic        Clk,
   input  logic [10:0] addr,
   output logic [7:0]  data
);
   logic [15:0][7:0] glyph;
   logic [3:0]       byte_idx;

   assign glyph    = glyph_bits(addr[10:4]);
   assign byte_idx = ~addr[3:0];   // row 0 lives in the top byte (index 15)

   always_ff @(posedge Clk) begin
      data <= glyph[byte_idx];
   end
endmodule

// File: rtl/text_overlay_renderer.sv
// Text box overlay: renders one stored message at a fixed origin with 2**SCALE_LOG2 scaling and blink.
// Ports: Clk, Reset (sync, active-high); bus (slave) carries frame_start, DrawX/DrawY, msg_sel,
// enable, blink_en in and pixel_on/in_box out, exactly 2 cycles after the pixel, no stalls.
module text_overlay_renderer
   import text_pkg::*;
#(
   parameter int N_MSGS       = 4,
   parameter int N_CHARS      = 16,
   parameter int ORIGIN_X     = 256,
   parameter int ORIGIN_Y     = 232,
   parameter int SCALE_LOG2   = 0,
   parameter int BLINK_FRAMES = 30
) (
   input logic                    Clk,
   input logic                    Reset,
   text_overlay_renderer_if.slave bus
);
   localparam int MSW   = (N_MSGS > 1) ? $clog2(N_MSGS) : 1;
   localparam int CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int BOX_W = (N_CHARS * GLYPH_W) << SCALE_LOG2;
   localparam int BOX_H = GLYPH_H << SCALE_LOG2;
   localparam int CIW   = $clog2(MSG_CHARS);

   // Per-frame state, updated only on frame_start.
   logic [MSW-1:0] msg_lat;
   logic           en_lat;
   logic           blink_lat;
   logic           phase;        // 1 = visible
   logic [CW-1:0]  frame_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         msg_lat   <= '0;
         en_lat    <= 1'b0;
         blink_lat <= 1'b0;
         phase     <= 1'b1;
         frame_cnt <= '0;
      end else if (bus.frame_start) begin
         msg_lat   <= bus.msg_sel;
         en_lat    <= bus.enable;
         blink_lat <= bus.blink_en;
         if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Box-relative coordinates; 11-bit signed so pixels left of/above the origin go negative.
   logic signed [10:0] rel_x, rel_y;
   logic               hit;
   logic [9:0]         col_px;
   logic [6:0]         char_idx;
   logic [3:0]         row_sel;
   logic [6:0]         code_nxt;

   assign rel_x    = $signed({1'b0, bus.DrawX}) - $signed(11'(ORIGIN_X));
   assign rel_y    = $signed({1'b0, bus.DrawY}) - $signed(11'(ORIGIN_Y));
   assign hit      = !rel_x[10] && !rel_y[10] &&
                     (int'(rel_x[9:0]) < BOX_W) && (int'(rel_y[9:0]) < BOX_H);
   assign col_px   = rel_x[9:0] >> SCALE_LOG2;
   assign char_idx = col_px[9:3];
   assign row_sel  = 4'(rel_y[9:0] >> SCALE_LOG2);

   // Message lookup is only indexed with in-range values; everything else is blank.
   always_comb begin
      code_nxt = CH_BLANK[6:0];
      if (hit && (int'(char_idx) < MSG_CHARS) && (int'(msg_lat) < MSG_COUNT)) begin
         code_nxt = MSG_TABLE[msg_lat][char_idx[CIW-1:0]][6:0];
      end
   end

   // S1: geometry and character code.
   logic       hit1;
   logic [2:0] bit1;
   logic [3:0] row1;
   logic [6:0] code1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit1  <= 1'b0;
         bit1  <= '0;
         row1  <= '0;
         code1 <= '0;
      end else begin
         hit1  <= hit;
         bit1  <= col_px[2:0];
         row1  <= row_sel;
         code1 <= code_nxt;
      end
   end

   // S2: glyph row from the font ROM, geometry carried alongside.
   logic       hit2;
   logic [2:0] bit2;
   logic [7:0] font_row;

   glyph_font_rom u_font (
      .Clk  (Clk),
      .addr ({code1, row1}),
      .data (font_row)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit2 <= 1'b0;
         bit2 <= '0;
      end else begin
         hit2 <= hit1;
         bit2 <= bit1;
      end
   end

   // Gating uses the frame state registered at output time, so a frame_start
   // landing inside the box shifts enable/blink by at most the pipeline depth.
   assign bus.pixel_on = hit2 & en_lat & (~blink_lat | phase) & font_row[~bit2];
   assign bus.in_box   = hit2 & en_lat;
endmodule

// File: tb/tb_text_overlay_renderer.sv
// Bench for text_overlay_renderer: two instances (scale 1x and 2x, blink period 2 frames)
// share one stimulus stream; results are compared with a string/arithmetic reference model.
module tb_text_overlay_renderer;
   import text_pkg::*;

   localparam int BF = 2;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic       fs = 1'b0;
   logic [9:0] dx = '0, dy = '0;
   logic [1:0] ms = '0;
   logic       en = 1'b0, bl = 1'b0;

   text_overlay_renderer_if #(.N_MSGS(4)) bus_a ();
   text_overlay_renderer_if #(.N_MSGS(4)) bus_b ();

   assign bus_a.frame_start = fs;  assign bus_b.frame_start = fs;
   assign bus_a.DrawX = dx;        assign bus_b.DrawX = dx;
   assign bus_a.DrawY = dy;        assign bus_b.DrawY = dy;
   assign bus_a.msg_sel = ms;      assign bus_b.msg_sel = ms;
   assign bus_a.enable = en;       assign bus_b.enable = en;
   assign bus_a.blink_en = bl;     assign bus_b.blink_en = bl;

   text_overlay_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(BF)) dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
   text_overlay_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(BF)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

   int checks = 0;
   int passed = 0;

   // Reference state: what the design should have latched, and frames since reset.
   string MSG_TEXT [4] = '{"PRESS START", "GAME OVER", "SCORE", "HI SCORE"};
   int    msg_m = 0;
   bit    en_m  = 1'b0;
   bit    blk_m = 1'b0;
   int    nfr   = 0;

   // {pixel_on, in_box} for a magnification of 2**scale.
   function automatic logic [1:0] ref_px(int scale, int x, int y);
      int rx, ry, cx, ci, r;
      logic [7:0]   c;
      logic [127:0] g;
      logic [7:0]   rowb;
      bit           vis;
      rx = x - 256;
      ry = y - 232;
      if (!(rx >= 0 && rx < (128 << scale) && ry >= 0 && ry < (16 << scale)) || !en_m)
         return 2'b00;
      cx  = rx >> scale;
      ci  = cx / 8;
      r   = (ry >> scale) % 16;
      c   = (ci < MSG_TEXT[msg_m].len()) ? MSG_TEXT[msg_m].getc(ci) : 8'h00;
      if (c == 8'h20) c = 8'h00;
      g    = glyph_bits(c[6:0]);
      rowb = g[127-8*r -: 8];
      vis  = ((nfr / BF) % 2) == 0;
      return {rowb[7 - (cx % 8)] && (!blk_m || vis), 1'b1};
   endfunction

   function automatic logic [3:0] ref4(int x, int y);
      return {ref_px(0, x, y), ref_px(1, x, y)};
   endfunction

   function automatic logic [3:0] outs();
      return {bus_a.pixel_on, bus_a.in_box, bus_b.pixel_on, bus_b.in_box};
   endfunction

   task automatic pulse_frame(input int m, input bit e, input bit b);
      @(posedge Clk); #1;
      dx = '0; dy = '0; ms = 2'(m); en = e; bl = b; fs = 1'b1;
      @(posedge Clk); #1;
      fs = 1'b0;
      msg_m = m; en_m = e; blk_m = b; nfr++;
   endtask

   // Presents one pixel and returns the outputs 2 cycles later.
   task automatic probe(input int x, input int y, output logic [3:0] got);
      @(posedge Clk); #1;
      dx = 10'(x); dy = 10'(y);
      @(posedge Clk);
      @(posedge Clk); #1;
      got = outs();
   endtask

   task automatic model_reset();
      msg_m = 0; en_m = 1'b0; blk_m = 1'b0; nfr = 0;
   endtask

   task automatic test_reset();
      logic [3:0] any;
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      model_reset();
      checks++;
      if (outs() !== 4'b0000) $display("FAIL reset_outputs got=%b exp=0000", outs());
      else passed++;
      any = '0;
      for (int y = 228; y < 268; y += 4) begin
         for (int x = 250; x < 520; x += 3) begin
            @(posedge Clk); #1;
            dx = 10'(x); dy = 10'(y);
            any |= outs();
         end
      end
      @(posedge Clk); @(posedge Clk); #1;
      any |= outs();
      checks++;
      if (any !== 4'b0000) $display("FAIL reset_no_frame_start got=%b exp=0000", any);
      else passed++;
   endtask

   task automatic test_basic();
      logic [3:0] got;
      int         px [10] = '{256, 262, 255, 384, 383, 256, 257, 256, 256, 511};
      int         py [10] = '{234, 234, 240, 240, 240, 236, 236, 263, 264, 240};
      logic [3:0] ex [10] = '{4'b1101, 4'b0101, 4'b0000, 4'b0001, 4'b0101,
                              4'b0111, 4'b1111, 4'b0001, 4'b0000, 4'b0001};
      pulse_frame(0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         probe(px[i], py[i], got);
         checks++;
         if (got !== ex[i]) $display("FAIL basic x=%0d y=%0d got=%b exp=%b", px[i], py[i], got, ex[i]);
         else passed++;
      end
      probe(512, 240, got);
      checks++;
      if (got !== 4'b0000) $display("FAIL scale2_right_edge got=%b exp=0000", got);
      else passed++;
   endtask

   task automatic test_frame_latch();
      logic [3:0] got, exp;
      int         x, y;
      pulse_frame(0, 1'b1, 1'b0);
      @(posedge Clk); #1;
      ms = 2'd1; en = 1'b0; bl = 1'b1;   // mid-frame changes must be ignored
      probe(256, 234, got);
      checks++;
      if (got !== 4'b1101) $display("FAIL latch_hold got=%b exp=1101", got);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         x = $urandom_range(250, 400); y = $urandom_range(230, 250);
         exp = ref4(x, y);
         probe(x, y, got);
         checks++;
         if (got !== exp) $display("FAIL latch_rand x=%0d y=%0d got=%b exp=%b", x, y, got, exp);
         else passed++;
      end
      pulse_frame(1, 1'b1, 1'b0);
      probe(256, 234, got);
      checks++;
      if (got !== 4'b0101) $display("FAIL latch_new_msg0 got=%b exp=0101", got);
      else passed++;
      probe(258, 234, got);
      checks++;
      if (got !== 4'b1101) $display("FAIL latch_new_msg2 got=%b exp=1101", got);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      logic [3:0] got;
      pulse_frame(0, 1'b1, 1'b0);
      @(posedge Clk); #1;
      dx = 10'd256; dy = 10'd234;
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (outs() !== 4'b0000) $display("FAIL midreset_flush got=%b exp=0000", outs());
      else passed++;
      @(posedge Clk); #1;
      Reset = 1'b0;
      model_reset();
      probe(256, 234, got);
      checks++;
      if (got !== 4'b0000) $display("FAIL midreset_hold got=%b exp=0000", got);
      else passed++;
      pulse_frame(0, 1'b1, 1'b0);
      probe(256, 234, got);
      checks++;
      if (got !== 4'b1101) $display("FAIL midreset_resume got=%b exp=1101", got);
      else passed++;
   endtask

   task automatic test_blink();
      logic [3:0] got, exp;
      for (int f = 0; f < 6; f++) begin
         pulse_frame(0, 1'b1, 1'b1);
         exp = ref4(257, 236);
         probe(257, 236, got);
         checks++;
         if (got !== exp) $display("FAIL blink frame=%0d got=%b exp=%b", nfr, got, exp);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [3:0] q [$];
      int         qx [$], qy [$];
      logic [3:0] got, exp;
      int         x, y, ex_x, ex_y;
      for (int f = 0; f < 6; f++) begin
         pulse_frame($urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
         for (int i = 0; i < 152; i++) begin
            @(posedge Clk); #1;
            if (i >= 2) begin
               exp = q.pop_front(); ex_x = qx.pop_front(); ex_y = qy.pop_front();
               got = outs();
               checks++;
               if (got !== exp)
                  $display("FAIL random frame=%0d x=%0d y=%0d got=%b exp=%b", nfr, ex_x, ex_y, got, exp);
               else passed++;
            end
            if (i < 150) begin
               if ($urandom_range(0, 7) == 0) begin
                  x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
               end else begin
                  x = $urandom_range(240, 530); y = $urandom_range(225, 270);
               end
               dx = 10'(x); dy = 10'(y);
               q.push_back(ref4(x, y)); qx.push_back(x); qy.push_back(y);
            end else begin
               dx = '0; dy = '0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_latch();
      test_reset_midframe();
      test_blink();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached passed=%0d checks=%0d", passed, checks);
      $fatal(1);
   end
endmodule
